// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer for Pong.
// Owns the game state machine, both score counters and the serve delay.
// Gates the ball controller through o_Game_Active / o_Ball_Reset.
// Every output is a register; none is combinational from an input.
module pong_match_ctrl #(
  parameter int c_GAME_WIDTH    = 40,
  parameter int c_PADDLE_HEIGHT = 6,
  parameter int c_SCORE_LIMIT   = 9,
  parameter int c_SERVE_FRAMES  = 60
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_VSync,
  input  logic       i_Game_Start,
  input  logic       i_Pause,
  input  logic [5:0] i_Ball_X,
  input  logic [5:0] i_Ball_Y,
  input  logic [5:0] i_Paddle_Y_P1,
  input  logic [5:0] i_Paddle_Y_P2,
  output logic       o_Game_Active,
  output logic       o_Ball_Reset,
  output logic       o_Serve_Dir,
  output logic [3:0] o_P1_Score,
  output logic [3:0] o_P2_Score,
  output logic       o_Game_Over,
  output logic       o_Winner,
  output logic       o_Frame_Tick,
  output logic [2:0] o_State
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_RUNNING   = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_POINT     = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_t;

  // The counter only has to reach c_SERVE_FRAMES-1.
  localparam int              CNT_W       = (c_SERVE_FRAMES > 1) ? $clog2(c_SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(c_SERVE_FRAMES - 1);
  localparam logic [3:0]      SCORE_LIMIT = 4'(c_SCORE_LIMIT);
  localparam logic [5:0]      P2_GOAL_X   = 6'(c_GAME_WIDTH - 1);
  localparam logic [6:0]      PADDLE_SPAN = 7'(c_PADDLE_HEIGHT - 1);

  // The paddle's bottom row is computed 7 bits wide, so a paddle near the
  // bottom edge cannot wrap and swallow rows at the top.
  function automatic logic outside_paddle(input logic [5:0] ball_y, input logic [5:0] paddle_y);
    logic [6:0] top_v;
    logic [6:0] bottom_v;
    top_v    = {1'b0, paddle_y};
    bottom_v = top_v + PADDLE_SPAN;
    return ({1'b0, ball_y} < top_v) || ({1'b0, ball_y} > bottom_v);
  endfunction

  // Output flags per state, packed as {game_active, ball_reset, game_over}.
  function automatic logic [2:0] state_flags(input state_t st);
    logic [2:0] flags_v;
    case (st)
      ST_IDLE:      flags_v = 3'b010;
      ST_SERVE:     flags_v = 3'b010;
      ST_RUNNING:   flags_v = 3'b100;
      ST_PAUSED:    flags_v = 3'b000;
      ST_POINT:     flags_v = 3'b010;
      ST_GAME_OVER: flags_v = 3'b011;
      default:      flags_v = 3'b010;
    endcase
    return flags_v;
  endfunction

  // Input sampling and edge detect registers
  logic vsync_r, vsync_d_r, frame_tick_r;
  logic start_r, start_d_r;
  logic pause_r, pause_d_r;

  // FSM and datapath registers
  state_t           state_r;
  logic [CNT_W-1:0] frame_cnt_r;
  logic [3:0]       p1_score_r, p2_score_r;
  logic             serve_dir_r, winner_r, scorer_r;
  logic             game_active_r, ball_reset_r, game_over_r;

  // Next-state values
  state_t           state_nxt_s;
  logic [CNT_W-1:0] frame_cnt_nxt_s;
  logic [3:0]       p1_score_nxt_s, p2_score_nxt_s;
  logic             serve_dir_nxt_s, winner_nxt_s, scorer_nxt_s;
  logic [2:0]       flags_nxt_s;

  logic start_edge_s, pause_edge_s, vsync_fall_s;
  logic p1_miss_s, p2_miss_s;
  logic [3:0] score_sel_s, score_inc_s;

  assign start_edge_s = start_r & ~start_d_r;
  assign pause_edge_s = pause_r & ~pause_d_r;
  assign vsync_fall_s = vsync_d_r & ~vsync_r;

  assign p1_miss_s = (i_Ball_X == 6'd0)      && outside_paddle(i_Ball_Y, i_Paddle_Y_P1);
  assign p2_miss_s = (i_Ball_X == P2_GOAL_X) && outside_paddle(i_Ball_Y, i_Paddle_Y_P2);

  // Saturating increment of the scorer's counter (scorer_r: 1 = P2)
  assign score_sel_s = scorer_r ? p2_score_r : p1_score_r;
  assign score_inc_s = (score_sel_s < SCORE_LIMIT) ? (score_sel_s + 4'd1) : score_sel_s;

  // Edge-detect registers reset high so a request held through reset
  // release is not mistaken for a fresh rising edge.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      vsync_r      <= 1'b1;
      vsync_d_r    <= 1'b1;
      frame_tick_r <= 1'b0;
      start_r      <= 1'b1;
      start_d_r    <= 1'b1;
      pause_r      <= 1'b1;
      pause_d_r    <= 1'b1;
    end else begin
      vsync_r      <= i_VSync;
      vsync_d_r    <= vsync_r;
      frame_tick_r <= vsync_fall_s;
      start_r      <= i_Game_Start;
      start_d_r    <= start_r;
      pause_r      <= i_Pause;
      pause_d_r    <= pause_r;
    end
  end

  // Next-state, score and serve decisions for the match FSM
  always_comb begin
    state_nxt_s     = state_r;
    frame_cnt_nxt_s = frame_cnt_r;
    p1_score_nxt_s  = p1_score_r;
    p2_score_nxt_s  = p2_score_r;
    serve_dir_nxt_s = serve_dir_r;
    winner_nxt_s    = winner_r;
    scorer_nxt_s    = scorer_r;
    case (state_r)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_edge_s) begin
          state_nxt_s     = ST_SERVE;
          p1_score_nxt_s  = 4'd0;
          p2_score_nxt_s  = 4'd0;
          serve_dir_nxt_s = 1'b1;
          frame_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_SERVE: begin
        if (frame_tick_r) begin
          if (frame_cnt_r == CNT_LAST) begin
            state_nxt_s     = ST_RUNNING;
            frame_cnt_nxt_s = '0;
          end else begin
            frame_cnt_nxt_s = frame_cnt_r + CNT_W'(1);
          end
        end else begin
          frame_cnt_nxt_s = frame_cnt_r;
        end
      end
      ST_RUNNING: begin
        // A miss wins over a simultaneous pause request.
        if (p1_miss_s) begin
          state_nxt_s  = ST_POINT;
          scorer_nxt_s = 1'b1;
        end else if (p2_miss_s) begin
          state_nxt_s  = ST_POINT;
          scorer_nxt_s = 1'b0;
        end else if (pause_edge_s) begin
          state_nxt_s = ST_PAUSED;
        end else begin
          state_nxt_s = ST_RUNNING;
        end
      end
      ST_PAUSED: begin
        if (pause_edge_s) begin
          state_nxt_s = ST_RUNNING;
        end else begin
          state_nxt_s = ST_PAUSED;
        end
      end
      ST_POINT: begin
        if (scorer_r) begin
          p2_score_nxt_s = score_inc_s;
        end else begin
          p1_score_nxt_s = score_inc_s;
        end
        if (score_inc_s == SCORE_LIMIT) begin
          state_nxt_s  = ST_GAME_OVER;
          winner_nxt_s = scorer_r;
        end else begin
          // Serve toward the player who just conceded.
          state_nxt_s     = ST_SERVE;
          frame_cnt_nxt_s = '0;
          serve_dir_nxt_s = ~scorer_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign flags_nxt_s = state_flags(state_nxt_s);

  // Match FSM state, scores and registered output flags
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_r       <= ST_IDLE;
      frame_cnt_r   <= '0;
      p1_score_r    <= 4'd0;
      p2_score_r    <= 4'd0;
      serve_dir_r   <= 1'b1;
      winner_r      <= 1'b0;
      scorer_r      <= 1'b0;
      game_active_r <= 1'b0;
      ball_reset_r  <= 1'b1;
      game_over_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      frame_cnt_r   <= frame_cnt_nxt_s;
      p1_score_r    <= p1_score_nxt_s;
      p2_score_r    <= p2_score_nxt_s;
      serve_dir_r   <= serve_dir_nxt_s;
      winner_r      <= winner_nxt_s;
      scorer_r      <= scorer_nxt_s;
      game_active_r <= flags_nxt_s[2];
      ball_reset_r  <= flags_nxt_s[1];
      game_over_r   <= flags_nxt_s[0];
    end
  end

  assign o_Game_Active = game_active_r;
  assign o_Ball_Reset  = ball_reset_r;
  assign o_Serve_Dir   = serve_dir_r;
  assign o_P1_Score    = p1_score_r;
  assign o_P2_Score    = p2_score_r;
  assign o_Game_Over   = game_over_r;
  assign o_Winner      = winner_r;
  assign o_Frame_Tick  = frame_tick_r;
  assign o_State       = state_r;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed bench for pong_match_ctrl with a short serve
// (2 frames) and a short match (first to 3).
module tb_pong_match_ctrl;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic       i_VSync;
  logic       i_Game_Start;
  logic       i_Pause;
  logic [5:0] i_Ball_X, i_Ball_Y;
  logic [5:0] i_Paddle_Y_P1, i_Paddle_Y_P2;
  logic       o_Game_Active, o_Ball_Reset, o_Serve_Dir;
  logic [3:0] o_P1_Score, o_P2_Score;
  logic       o_Game_Over, o_Winner, o_Frame_Tick;
  logic [2:0] o_State;

  int n_checks = 0;
  int n_fails  = 0;

  localparam int ST_IDLE = 0, ST_SERVE = 1, ST_RUNNING = 2, ST_PAUSED = 3, ST_POINT = 4, ST_GAME_OVER = 5;

  pong_match_ctrl #(
    .c_GAME_WIDTH(40), .c_PADDLE_HEIGHT(6), .c_SCORE_LIMIT(3), .c_SERVE_FRAMES(2)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_VSync(i_VSync),
    .i_Game_Start(i_Game_Start), .i_Pause(i_Pause),
    .i_Ball_X(i_Ball_X), .i_Ball_Y(i_Ball_Y),
    .i_Paddle_Y_P1(i_Paddle_Y_P1), .i_Paddle_Y_P2(i_Paddle_Y_P2),
    .o_Game_Active(o_Game_Active), .o_Ball_Reset(o_Ball_Reset), .o_Serve_Dir(o_Serve_Dir),
    .o_P1_Score(o_P1_Score), .o_P2_Score(o_P2_Score),
    .o_Game_Over(o_Game_Over), .o_Winner(o_Winner),
    .o_Frame_Tick(o_Frame_Tick), .o_State(o_State)
  );

  // 100 MHz clock
  always #5 i_Clk = ~i_Clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic start_pulse();
    i_Game_Start = 1'b1;
    step();
    i_Game_Start = 1'b0;
    step();
  endtask

  // One VSync low cycle; the tick shows two edges later and is consumed on the third.
  task automatic vsync_pulse();
    i_VSync = 1'b0;
    step();
    check_eq("tick_not_yet", o_Frame_Tick, 0);
    i_VSync = 1'b1;
    step();
    check_eq("tick_high", o_Frame_Tick, 1);
    step();
    check_eq("tick_cleared", o_Frame_Tick, 0);
  endtask

  task automatic to_running();
    vsync_pulse();
    check_eq("serve_after_1_frame", o_State, ST_SERVE);
    vsync_pulse();
    check_eq("running_after_2_frames", o_State, ST_RUNNING);
    check_eq("running_active", o_Game_Active, 1);
    check_eq("running_ball_reset", o_Ball_Reset, 0);
  endtask

  task automatic ball_at(input int x, input int y);
    i_Ball_X = 6'(x);
    i_Ball_Y = 6'(y);
  endtask

  // Present a miss for one edge (-> POINT), then recentre for the POINT cycle.
  task automatic score_point(input int x, input int y);
    ball_at(x, y);
    step();
    check_eq("point_state", o_State, ST_POINT);
    check_eq("point_inactive", o_Game_Active, 0);
    ball_at(20, 15);
    step();
  endtask

  initial begin
    i_Rst = 1'b1; i_VSync = 1'b1; i_Game_Start = 1'b0; i_Pause = 1'b0;
    i_Paddle_Y_P1 = 6'd10; i_Paddle_Y_P2 = 6'd10;
    ball_at(20, 15);
    steps(3);
    check_eq("rst_state", o_State, ST_IDLE);
    check_eq("rst_p1", o_P1_Score, 0);
    check_eq("rst_p2", o_P2_Score, 0);
    check_eq("rst_serve_dir", o_Serve_Dir, 1);
    check_eq("rst_winner", o_Winner, 0);
    check_eq("rst_game_over", o_Game_Over, 0);
    check_eq("rst_active", o_Game_Active, 0);
    check_eq("rst_ball_reset", o_Ball_Reset, 1);
    check_eq("rst_tick", o_Frame_Tick, 0);
    i_Rst = 1'b0;
    steps(2);

    // Start: one edge of latency in the edge detector
    i_Game_Start = 1'b1;
    step();
    check_eq("start_latency_idle", o_State, ST_IDLE);
    i_Game_Start = 1'b0;
    step();
    check_eq("start_serve", o_State, ST_SERVE);
    check_eq("start_ball_reset", o_Ball_Reset, 1);
    check_eq("start_p1", o_P1_Score, 0);
    check_eq("start_p2", o_P2_Score, 0);
    to_running();

    // P1 paddle rows 10..15 are inclusive
    ball_at(0, 10); step();
    check_eq("p1_top_edge_hit", o_State, ST_RUNNING);
    ball_at(0, 15); step();
    check_eq("p1_bottom_edge_hit", o_State, ST_RUNNING);
    score_point(0, 16);
    check_eq("below_p1_serve", o_State, ST_SERVE);
    check_eq("below_p1_p2score", o_P2_Score, 1);
    check_eq("below_p1_dir", o_Serve_Dir, 0);
    to_running();
    score_point(0, 9);
    check_eq("above_p1_serve", o_State, ST_SERVE);
    check_eq("above_p1_p2score", o_P2_Score, 2);
    check_eq("above_p1_dir", o_Serve_Dir, 0);
    to_running();

    // Pause, long hold, ignored start, resume
    i_Pause = 1'b1;
    step();
    check_eq("pause_latency", o_State, ST_RUNNING);
    step();
    check_eq("paused_state", o_State, ST_PAUSED);
    check_eq("paused_active", o_Game_Active, 0);
    check_eq("paused_ball_reset", o_Ball_Reset, 0);
    steps(100);
    check_eq("pause_hold_no_toggle", o_State, ST_PAUSED);
    i_Pause = 1'b0;
    start_pulse();
    step();
    check_eq("paused_start_ignored", o_State, ST_PAUSED);
    i_Pause = 1'b1;
    steps(2);
    check_eq("resume_running", o_State, ST_RUNNING);
    check_eq("resume_active", o_Game_Active, 1);

    // Pause edge and P1 miss on the same edge: miss wins (P2 reaches 3)
    i_Pause = 1'b0;
    step();
    i_Pause = 1'b1;
    step();
    ball_at(0, 30);
    step();
    check_eq("simul_point", o_State, ST_POINT);
    i_Pause = 1'b0;
    ball_at(20, 15);
    step();
    check_eq("p2_win_state", o_State, ST_GAME_OVER);
    check_eq("p2_win_score", o_P2_Score, 3);
    check_eq("p2_win_winner", o_Winner, 1);
    check_eq("p2_win_over", o_Game_Over, 1);
    check_eq("p2_win_ball_reset", o_Ball_Reset, 1);
    ball_at(0, 30);
    steps(3);
    check_eq("p2_score_held", o_P2_Score, 3);
    ball_at(20, 15);

    // Restart from GAME_OVER
    start_pulse();
    check_eq("restart_state", o_State, ST_SERVE);
    check_eq("restart_p1", o_P1_Score, 0);
    check_eq("restart_p2", o_P2_Score, 0);
    check_eq("restart_dir", o_Serve_Dir, 1);
    check_eq("restart_over", o_Game_Over, 0);

    // P1 wins with three P2-side misses
    to_running();
    ball_at(39, 15); step();
    check_eq("p2_paddle_edge_hit", o_State, ST_RUNNING);
    score_point(39, 30);
    check_eq("p1_first_point", o_P1_Score, 1);
    check_eq("p1_first_dir", o_Serve_Dir, 1);
    to_running();
    score_point(39, 4);
    check_eq("p1_second_point", o_P1_Score, 2);
    to_running();
    score_point(39, 30);
    check_eq("p1_win_state", o_State, ST_GAME_OVER);
    check_eq("p1_win_score", o_P1_Score, 3);
    check_eq("p1_win_winner", o_Winner, 0);
    check_eq("p1_win_over", o_Game_Over, 1);
    ball_at(39, 30);
    steps(3);
    check_eq("p1_score_held", o_P1_Score, 3);
    ball_at(20, 15);

    // Reset in the middle of a serve at 2/1
    start_pulse();
    to_running();
    score_point(39, 30);
    to_running();
    score_point(0, 30);
    to_running();
    score_point(39, 30);
    check_eq("pre_rst_p1", o_P1_Score, 2);
    check_eq("pre_rst_p2", o_P2_Score, 1);
    vsync_pulse();
    check_eq("pre_rst_serve", o_State, ST_SERVE);
    i_Rst = 1'b1;
    #1;
    check_eq("async_rst_state", o_State, ST_IDLE);
    check_eq("async_rst_p1", o_P1_Score, 0);
    check_eq("async_rst_p2", o_P2_Score, 0);
    check_eq("async_rst_ball_reset", o_Ball_Reset, 1);
    i_Game_Start = 1'b1;
    steps(2);
    i_Rst = 1'b0;
    steps(4);
    check_eq("held_start_no_edge", o_State, ST_IDLE);
    i_Game_Start = 1'b0;
    step();
    start_pulse();
    check_eq("fresh_start_serve", o_State, ST_SERVE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
